// File: rtl/ring_counter_pkg.sv
// Shared constants for the one-hot ring counter: default geometry, seed and
// rotation-direction encodings.
package ring_counter_pkg;

    localparam int unsigned     RING_WIDTH_DEFAULT = 4;
    localparam logic [31:0]     RING_SEED_LSB      = 32'd1;
    localparam logic [3:0]      RING_SEED_DEFAULT  = 4'b0001;

    localparam bit              RING_DIR_UP        = 1'b0;
    localparam bit              RING_DIR_DOWN      = 1'b1;

endpackage

// File: rtl/onehot_check.sv
// Combinational detector: is_onehot is high when exactly one bit of vec is set.
module onehot_check #(
    parameter int unsigned WIDTH = 4
) (
    input  logic [WIDTH-1:0] vec,
    output logic             is_onehot
);

    logic seen;
    logic multi;

    // Track "at least one" and "more than one" instead of a full popcount.
    always_comb begin
        seen  = 1'b0;
        multi = 1'b0;
        for (int unsigned i = 0; i < WIDTH; i++) begin
            if (vec[i]) begin
                if (seen) multi = 1'b1;
                seen = 1'b1;
            end
        end
        is_onehot = seen & ~multi;
    end

endmodule

// File: rtl/ring_counter.sv
// Parameterised one-hot ring counter with asynchronous clear and optional
// recovery of illegal (non-one-hot) states back to the seed pattern.
module ring_counter
    import ring_counter_pkg::*;
#(
    parameter int unsigned      WIDTH        = RING_WIDTH_DEFAULT,
    parameter logic [WIDTH-1:0] SEED         = WIDTH'(RING_SEED_LSB),
    parameter bit               DIR          = RING_DIR_UP,
    parameter bit               SELF_CORRECT = 1'b1
) (
    input  logic             clk,
    input  logic             clr,
    output logic [WIDTH-1:0] Q
);

    // Initial value gives a defined power-on state even without a clear.
    logic [WIDTH-1:0] state = SEED;
    logic [WIDTH-1:0] rotated;
    logic [WIDTH-1:0] next_state;
    logic             is_onehot;

    onehot_check #(
        .WIDTH(WIDTH)
    ) u_onehot_check (
        .vec      (state),
        .is_onehot(is_onehot)
    );

    always_comb begin
        if (DIR == RING_DIR_UP) begin
            rotated = {state[WIDTH-2:0], state[WIDTH-1]};
        end else begin
            rotated = {state[0], state[WIDTH-1:1]};
        end
        next_state = (SELF_CORRECT && !is_onehot) ? SEED : rotated;
    end

    always_ff @(posedge clk or posedge clr) begin
        if (clr) begin
            state <= SEED;
        end else begin
            state <= next_state;
        end
    end

    assign Q = state;

endmodule

// File: tb/tb_ring_counter.sv
// Self-checking bench for ring_counter: vector tables, directed corner cases
// and a randomized run against a phase-index reference model.
module tb_ring_counter;

    logic       clk = 1'b0;
    logic       clr = 1'b0;
    logic       clr_dn = 1'b1;
    logic       clr8 = 1'b1;
    logic [3:0] q;
    logic [3:0] q_dn;
    logic [7:0] q8;

    int errors = 0;
    int checks = 0;

    always #5 clk = ~clk;

    ring_counter #(.WIDTH(4), .SEED(4'b0001), .DIR(1'b0), .SELF_CORRECT(1'b1))
        dut (.clk(clk), .clr(clr), .Q(q));
    ring_counter #(.WIDTH(4), .SEED(4'b0001), .DIR(1'b1), .SELF_CORRECT(1'b1))
        dut_dn (.clk(clk), .clr(clr_dn), .Q(q_dn));
    ring_counter #(.WIDTH(8), .SEED(8'b0000_0001), .DIR(1'b0), .SELF_CORRECT(1'b1))
        dut8 (.clk(clk), .clr(clr8), .Q(q8));

    typedef struct {
        bit         clr_v;
        logic [3:0] exp;
    } vec_t;

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %b expected %b at %0t", name, got, exp, $time);
        end
    endtask

    // Sample 1 ns after the rising edge.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Reference model: the counter sits at a phase index; the output is the
    // one-hot code of that phase, and anything that is not a single set bit
    // returns to phase 0.
    function automatic logic [3:0] model_next(input logic [3:0] cur);
        int ones = 0;
        int idx  = 0;
        logic [3:0] res;
        for (int i = 0; i < 4; i++) begin
            if (cur[i]) begin
                ones++;
                idx = i;
            end
        end
        res = '0;
        if (ones != 1) res[0] = 1'b1;
        else           res[(idx + 1) % 4] = 1'b1;
        return res;
    endfunction

    task automatic inject(input logic [3:0] v);
        force dut.state = v;
        #1;
        release dut.state;
    endtask

    initial begin
        vec_t       tbl[10];
        logic [3:0] mdl;
        logic [3:0] exp_dn[5];
        logic [7:0] exp8;

        // Power-on value without any clear.
        #1;
        check("poweron", q, 4'b0001);

        // Free run: expected Q after each edge.
        tbl[0] = '{1'b0, 4'b0010}; tbl[1] = '{1'b0, 4'b0100};
        tbl[2] = '{1'b0, 4'b1000}; tbl[3] = '{1'b0, 4'b0001};
        tbl[4] = '{1'b0, 4'b0010}; tbl[5] = '{1'b0, 4'b0100};
        tbl[6] = '{1'b0, 4'b1000}; tbl[7] = '{1'b0, 4'b0001};
        tbl[8] = '{1'b0, 4'b0010}; tbl[9] = '{1'b0, 4'b0100};
        for (int i = 0; i < 10; i++) begin
            clr = tbl[i].clr_v;
            tick();
            check($sformatf("freerun[%0d]", i), q, tbl[i].exp);
        end

        // Mid-cycle async clear while Q=0100.
        #2;
        clr = 1'b1;
        #1;
        check("async_clr", q, 4'b0001);
        for (int i = 0; i < 5; i++) begin
            tick();
            check($sformatf("clr_hold[%0d]", i), q, 4'b0001);
        end
        @(negedge clk);
        clr = 1'b0;
        tick();
        check("first_after_release", q, 4'b0010);

        // Wrap-around / period.
        @(negedge clk);
        clr = 1'b1;
        @(negedge clk);
        clr = 1'b0;
        for (int i = 0; i < 4; i++) tick();
        check("period4", q, 4'b0001);
        for (int i = 0; i < 8; i++) tick();
        check("period8", q, 4'b0001);

        // DIR=1 instance.
        @(negedge clk);
        clr_dn = 1'b0;
        exp_dn[0] = 4'b1000; exp_dn[1] = 4'b0100; exp_dn[2] = 4'b0010;
        exp_dn[3] = 4'b0001; exp_dn[4] = 4'b1000;
        check("dn_seed", q_dn, 4'b0001);
        for (int i = 0; i < 5; i++) begin
            tick();
            check($sformatf("dn[%0d]", i), q_dn, exp_dn[i]);
        end

        // Illegal-state recovery and a legal wrap.
        @(negedge clk);
        inject(4'b0000);
        check("inject_zero", q, 4'b0000);
        tick();
        check("recover_zero", q, 4'b0001);
        @(negedge clk);
        inject(4'b0110);
        tick();
        check("recover_0110", q, 4'b0001);
        @(negedge clk);
        inject(4'b1000);
        tick();
        check("legal_wrap", q, 4'b0001);
        @(negedge clk);
        inject(4'b1111);
        tick();
        check("recover_1111", q, 4'b0001);

        // WIDTH=8 instance.
        @(negedge clk);
        clr8 = 1'b0;
        exp8 = 8'b0000_0001;
        for (int i = 1; i <= 8; i++) begin
            tick();
            exp8 = {exp8[6:0], exp8[7]};
            check($sformatf("w8[%0d]", i), q8, exp8);
        end
        check("w8_edge8", q8, 8'b0000_0001);

        // Randomized run: clears, illegal injections and free counting.
        @(negedge clk);
        mdl = q === 4'b0001 ? 4'b0001 : 4'bxxxx;
        clr = 1'b1;
        #1;
        mdl = 4'b0001;
        check("rnd_init", q, mdl);
        for (int i = 0; i < 300; i++) begin
            int unsigned r;
            @(negedge clk);
            r = $urandom_range(0, 9);
            if (r == 0) begin
                clr = 1'b1;
                #1;
                mdl = 4'b0001;
                check("rnd_async", q, mdl);
            end else begin
                clr = 1'b0;
                if (r == 1) begin
                    mdl = 4'($urandom_range(0, 15));
                    inject(mdl);
                end
            end
            tick();
            mdl = clr ? 4'b0001 : model_next(mdl);
            check($sformatf("rnd[%0d]", i), q, mdl);
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout: simulation exceeded time limit");
        $fatal(1, "timeout");
    end

endmodule
